ysyx_24110015_axi_arbiter: RTL and testbench
============================================

# ysyx_24110015_axi_arbiter

Two-to-one AXI-lite arbiter sharing the single memory-side AXI-lite slave between the IFU (master 0) and the LSU (master 1). Whole transactions are arbitrated: one granted master owns the slave from address acceptance until its response handshake completes. Sits between the core's fetch and load/store units and the memory/crossbar port.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports; wstrb is DATA_W/8

- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- ifu  axi_lite_if.slave  —  master 0 request port (full AR/R/AW/W/B channel set)
- lsu  axi_lite_if.slave  —  master 1 request port
- mem  axi_lite_if.master  —  shared downstream port

## Operation
- Request: master m requests read when m.arvalid=1, write when m.awvalid=1 or m.wvalid=1. If both, read is served first.
- States: IDLE, M0_RD, M0_WR, M1_RD, M1_WR.
- IDLE: all ready/valid outputs to masters and all valid/ready outputs to mem are 0. On any request, pick winner, go to Mx_RD or Mx_WR next cycle.
- Mx_RD: mem.araddr/arsize/arvalid/rready driven from master x; x.arready/rdata/rresp/rvalid driven from mem. Exit to IDLE on cycle after mem.rvalid & mem.rready.
- Mx_WR: aw, w and b channels forwarded between x and mem; aw and w may complete in any order or same cycle. Exit to IDLE on cycle after mem.bvalid & mem.bready.
- Non-granted master: arready, awready, wready, rvalid, bvalid held 0; its valids remain pending and must stay asserted (AXI rule).
- rdata/rresp/bresp passed through unchanged; error responses not interpreted.
- Address/data/strb outputs to mem are don't-care when corresponding valid is 0; implementation drives 0.
- Winner selection: per Configuration. Last-grant register updated on every IDLE→grant transition.

## Timing
- Reset: state=IDLE, last_grant=M0; all outputs 0 in the cycle following rst high. Reset mid-transaction abandons it; no response is forwarded afterward.
- Arbitration latency: 1 cycle. Request seen in IDLE at cycle n; forwarding begins cycle n+1.
- Forwarding is combinational in grant states: mem.arvalid follows granted arvalid same cycle; master ready follows mem ready same cycle.
- Turnaround: 1 idle cycle after each response handshake before next grant; back-to-back transactions from the same master therefore cost ≥1 bubble.
- Simultaneous requests in IDLE: one winner per cycle, loser waits in place.
- Response arriving same cycle as address handshake (zero-latency slave) completes normally; exit on that handshake.
- No timeout: a slave that never responds holds the grant indefinitely.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on tie, grant the master not in last_grant (after reset, LSU wins first tie).
- Undefined: fixed priority, LSU (master 1) always wins ties; last_grant register still present but unused for selection.
- Single-requester behaviour identical in both builds.

## Structure
- Package ysyx_24110015_arb_pkg: state enum (IDLE, M0_RD, M0_WR, M1_RD, M1_WR), master-id typedef (M0/M1), op typedef (RD/WR).
- Sub-module ysyx_24110015_arb_pick: combinational picker, inputs req[1:0], last_grant; outputs winner id and op; contains the ARB_ROUND_ROBIN_EN selection.
- Top holds FSM, last_grant register and channel muxes.

## Test plan
- IFU read alone: ifu.araddr=0x8000_0000, mem returns rdata=0x0000_0413 two cycles later -> mem.arvalid high cycle n+1, ifu.rvalid with 0x0000_0413, state back to IDLE cycle after r handshake; lsu ports all 0.
- LSU write, AW at cycle 1 and W at cycle 3, wstrb=0x4, wdata=0x00AB_0000 -> mem sees identical values, lsu.bvalid forwarded, ifu.arready stays 0 throughout.
- Simultaneous IFU read and LSU read in IDLE, repeated 4 times -> fixed build: LSU granted all ties; round-robin build: LSU, IFU, LSU, IFU.
- LSU asserts arvalid and awvalid together -> read transaction first, then write after 1 idle cycle.
- rst asserted mid M1_WR after aw handshake -> next cycle state IDLE, all outputs 0, later mem.bvalid not forwarded to lsu.
- Slave returns rresp=2'b10 (SLVERR) to IFU -> ifu.rresp=2'b10 unchanged, arbiter returns to IDLE normally.

Source files
------------

// File: rtl/ysyx_24110015_arb_pkg.sv
// Shared types for the two-master AXI-lite arbiter.
//   state_t : arbiter FSM states (idle plus one grant state per master/op)
//   mid_t   : master id (M0 = IFU, M1 = LSU)
//   op_t    : transaction kind (RD / WR)
package ysyx_24110015_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    M0_RD = 3'd1,
    M0_WR = 3'd2,
    M1_RD = 3'd3,
    M1_WR = 3'd4
  } state_t;

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} mid_t;

  typedef enum logic {RD = 1'b0, WR = 1'b1} op_t;

  function automatic state_t grant_state(mid_t id, op_t op);
    if (id == M1) return (op == RD) ? M1_RD : M1_WR;
    return (op == RD) ? M0_RD : M0_WR;
  endfunction

endpackage

// File: rtl/ysyx_24110015_arb_pick.sv
// Combinational winner picker for the AXI-lite arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it the LSU (M1) always wins a tie.
// Ports:
//   req_rd[1:0]  read request per master (arvalid)
//   req_wr[1:0]  write request per master (awvalid | wvalid)
//   last_grant   master granted most recently
//   valid        at least one master is requesting
//   winner       selected master
//   op           selected operation for the winner (reads before writes)
module ysyx_24110015_arb_pick
  import ysyx_24110015_arb_pkg::*;
(
  input  logic [1:0] req_rd,
  input  logic [1:0] req_wr,
  input  mid_t       last_grant,
  output logic       valid,
  output mid_t       winner,
  output op_t        op
);

  logic [1:0] req;
  logic       winner_rd;

  assign req   = req_rd | req_wr;
  assign valid = |req;

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; the register still exists in the top.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    winner = M0;
    if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_grant == M0) ? M1 : M0;
`else
      winner = M1;
`endif
    end else if (req[1]) begin
      winner = M1;
    end
  end

  assign winner_rd = (winner == M1) ? req_rd[1] : req_rd[0];
  assign op        = winner_rd ? RD : WR;

endmodule

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-to-one AXI-lite arbiter: IFU (master 0) and LSU (master 1) share
// one memory-side slave. A granted master owns the slave from address
// acceptance until its response handshake; one idle cycle follows.
// Build option: ARB_ROUND_ROBIN_EN (see ysyx_24110015_arb_pick).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ifu_*, lsu_*    master-side AR/R/AW/W/B channels (arbiter is slave)
//   mem_*           shared downstream AR/R/AW/W/B channels (arbiter is master)
module ysyx_24110015_axi_arbiter
  import ysyx_24110015_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [2:0]          ifu_arsize,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   ifu_awaddr,
  input  logic                ifu_awvalid,
  output logic                ifu_awready,
  input  logic [DATA_W-1:0]   ifu_wdata,
  input  logic [DATA_W/8-1:0] ifu_wstrb,
  input  logic                ifu_wvalid,
  output logic                ifu_wready,
  output logic [1:0]          ifu_bresp,
  output logic                ifu_bvalid,
  input  logic                ifu_bready,
  // LSU
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // memory side
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic [2:0]          mem_arsize,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic [1:0]          mem_bresp,
  input  logic                mem_bvalid,
  output logic                mem_bready
);

  state_t state_q, state_d;
  mid_t   last_grant_q, last_grant_d;
  logic   pick_valid;
  mid_t   pick_id;
  op_t    pick_op;

  ysyx_24110015_arb_pick u_pick (
    .req_rd     ({lsu_arvalid, ifu_arvalid}),
    .req_wr     ({lsu_awvalid | lsu_wvalid, ifu_awvalid | ifu_wvalid}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_id),
    .op         (pick_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= M0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = grant_state(pick_id, pick_op);
          last_grant_d = pick_id;
        end
      end
      M0_RD, M1_RD: if (mem_rvalid && mem_rready) state_d = IDLE;
      M0_WR, M1_WR: if (mem_bvalid && mem_bready) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  logic rd_act, wr_act, sel_lsu;
  assign rd_act  = (state_q == M0_RD) || (state_q == M1_RD);
  assign wr_act  = (state_q == M0_WR) || (state_q == M1_WR);
  assign sel_lsu = (state_q == M1_RD) || (state_q == M1_WR);

  // Request-side fields of whichever master holds the grant.
  logic [ADDR_W-1:0]   s_araddr, s_awaddr;
  logic [2:0]          s_arsize;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

  assign s_araddr  = sel_lsu ? lsu_araddr  : ifu_araddr;
  assign s_arsize  = sel_lsu ? lsu_arsize  : ifu_arsize;
  assign s_arvalid = sel_lsu ? lsu_arvalid : ifu_arvalid;
  assign s_rready  = sel_lsu ? lsu_rready  : ifu_rready;
  assign s_awaddr  = sel_lsu ? lsu_awaddr  : ifu_awaddr;
  assign s_awvalid = sel_lsu ? lsu_awvalid : ifu_awvalid;
  assign s_wdata   = sel_lsu ? lsu_wdata   : ifu_wdata;
  assign s_wstrb   = sel_lsu ? lsu_wstrb   : ifu_wstrb;
  assign s_wvalid  = sel_lsu ? lsu_wvalid  : ifu_wvalid;
  assign s_bready  = sel_lsu ? lsu_bready  : ifu_bready;

  always_comb begin
    mem_araddr  = '0;
    mem_arsize  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    mem_awaddr  = '0;
    mem_awvalid = 1'b0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_wvalid  = 1'b0;
    mem_bready  = 1'b0;
    if (rd_act) begin
      mem_arvalid = s_arvalid;
      mem_araddr  = s_arvalid ? s_araddr : '0;
      mem_arsize  = s_arvalid ? s_arsize : '0;
      mem_rready  = s_rready;
    end
    if (wr_act) begin
      mem_awvalid = s_awvalid;
      mem_awaddr  = s_awvalid ? s_awaddr : '0;
      mem_wvalid  = s_wvalid;
      mem_wdata   = s_wvalid ? s_wdata : '0;
      mem_wstrb   = s_wvalid ? s_wstrb : '0;
      mem_bready  = s_bready;
    end
  end

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_awready = 1'b0;
    ifu_wready  = 1'b0;
    ifu_bvalid  = 1'b0;
    ifu_bresp   = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    case (state_q)
      M0_RD: begin
        ifu_arready = mem_arready;
        ifu_rvalid  = mem_rvalid;
        ifu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
      end
      M0_WR: begin
        ifu_awready = mem_awready;
        ifu_wready  = mem_wready;
        ifu_bvalid  = mem_bvalid;
        ifu_bresp   = mem_bresp;
      end
      M1_RD: begin
        lsu_arready = mem_arready;
        lsu_rvalid  = mem_rvalid;
        lsu_rdata   = mem_rdata;
        lsu_rresp   = mem_rresp;
      end
      M1_WR: begin
        lsu_awready = mem_awready;
        lsu_wready  = mem_wready;
        lsu_bvalid  = mem_bvalid;
        lsu_bresp   = mem_bresp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
module tb_ysyx_24110015_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, ifu_awaddr, ifu_wdata, lsu_araddr, lsu_awaddr, lsu_wdata;
  logic [2:0]  ifu_arsize, lsu_arsize, mem_arsize;
  logic [3:0]  ifu_wstrb, lsu_wstrb, mem_wstrb;
  logic        ifu_arvalid, ifu_rready, ifu_awvalid, ifu_wvalid, ifu_bready;
  logic        lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready;
  logic        ifu_arready, ifu_rvalid, ifu_awready, ifu_wready, ifu_bvalid;
  logic        lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
  logic [31:0] ifu_rdata, lsu_rdata, mem_rdata;
  logic [1:0]  ifu_rresp, ifu_bresp, lsu_rresp, lsu_bresp, mem_rresp, mem_bresp;
  logic [31:0] mem_araddr, mem_awaddr, mem_wdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_24110015_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_awaddr(ifu_awaddr),
    .ifu_awvalid(ifu_awvalid), .ifu_awready(ifu_awready), .ifu_wdata(ifu_wdata),
    .ifu_wstrb(ifu_wstrb), .ifu_wvalid(ifu_wvalid), .ifu_wready(ifu_wready),
    .ifu_bresp(ifu_bresp), .ifu_bvalid(ifu_bvalid), .ifu_bready(ifu_bready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_awaddr(lsu_awaddr),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .mem_araddr(mem_araddr), .mem_arsize(mem_arsize), .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_awaddr(mem_awaddr),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
  );

  logic ifu_any, lsu_any, mem_any;
  assign ifu_any = |{ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
                     ifu_awready, ifu_wready, ifu_bvalid, ifu_bresp};
  assign lsu_any = |{lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
                     lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp};
  assign mem_any = |{mem_araddr, mem_arsize, mem_arvalid, mem_rready, mem_awaddr,
                     mem_awvalid, mem_wdata, mem_wstrb, mem_wvalid, mem_bready};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_araddr = '0; ifu_arsize = '0; ifu_arvalid = 0; ifu_rready = 0;
    ifu_awaddr = '0; ifu_awvalid = 0; ifu_wdata = '0; ifu_wstrb = '0;
    ifu_wvalid = 0; ifu_bready = 0;
    lsu_araddr = '0; lsu_arsize = '0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_wvalid = 0; lsu_bready = 0;
    mem_arready = 0; mem_rdata = '0; mem_rresp = '0; mem_rvalid = 0;
    mem_awready = 0; mem_wready = 0; mem_bresp = '0; mem_bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  logic exp_lsu;

  initial begin
    // ---------------- reset: outputs quiet even with slave activity
    clear_inputs();
    rst = 1;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678; mem_bvalid = 1;
    ifu_rready = 1; lsu_bready = 1;
    step();
    #1;
    chk("rst_ifu_out", ifu_any, 0);
    chk("rst_lsu_out", lsu_any, 0);
    chk("rst_mem_out", mem_any, 0);
    clear_inputs();
    rst = 0;

    // ---------------- IFU read alone
    step();
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arsize = 3'd2;
    ifu_rready = 1; mem_arready = 1;
    #1;
    chk("rd_idle_arvalid", mem_arvalid, 0);
    step();
    chk("rd_mem_arvalid", mem_arvalid, 1);
    chk("rd_mem_araddr", mem_araddr, 32'h8000_0000);
    chk("rd_mem_arsize", mem_arsize, 3'd2);
    chk("rd_ifu_arready", ifu_arready, 1);
    step();
    ifu_arvalid = 0; ifu_araddr = '0;
    #1;
    chk("rd_araddr_zero", mem_araddr, 0);
    step();
    mem_rvalid = 1; mem_rdata = 32'h0000_0413;
    #1;
    chk("rd_ifu_rvalid", ifu_rvalid, 1);
    chk("rd_ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk("rd_mem_rready", mem_rready, 1);
    chk("rd_lsu_quiet", lsu_any, 0);
    step();
    mem_rvalid = 0;
    #1;
    chk("rd_back_idle", mem_rready, 0);

    // ---------------- LSU write, AW then W two cycles later
    step();
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0100; lsu_bready = 1;
    mem_awready = 1; mem_wready = 1; mem_arready = 1;
    #1;
    chk("wr_idle_awvalid", mem_awvalid, 0);
    step();
    chk("wr_mem_awvalid", mem_awvalid, 1);
    chk("wr_mem_awaddr", mem_awaddr, 32'h8000_0100);
    chk("wr_lsu_awready", lsu_awready, 1);
    chk("wr_ifu_arready0", ifu_arready, 0);
    step();
    lsu_awvalid = 0; lsu_awaddr = '0;
    #1;
    chk("wr_aw_done", mem_awvalid, 0);
    step();
    lsu_wvalid = 1; lsu_wdata = 32'h00AB_0000; lsu_wstrb = 4'h4;
    #1;
    chk("wr_mem_wvalid", mem_wvalid, 1);
    chk("wr_mem_wdata", mem_wdata, 32'h00AB_0000);
    chk("wr_mem_wstrb", mem_wstrb, 4'h4);
    chk("wr_lsu_wready", lsu_wready, 1);
    chk("wr_ifu_arready1", ifu_arready, 0);
    step();
    lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_bvalid = 1;
    #1;
    chk("wr_lsu_bvalid", lsu_bvalid, 1);
    chk("wr_mem_bready", mem_bready, 1);
    chk("wr_ifu_quiet", ifu_any, 0);
    step();
    mem_bvalid = 0;
    #1;
    chk("wr_back_idle", mem_bready, 0);

    // ---------------- simultaneous reads, four rounds from reset
    do_reset();
    mem_arready = 1; ifu_rready = 1; lsu_rready = 1;
    ifu_araddr = 32'h0000_0100; lsu_araddr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_lsu = (i % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      ifu_arvalid = 1; lsu_arvalid = 1;
      step();
      chk($sformatf("tie%0d_lsu_arready", i), lsu_arready, exp_lsu);
      chk($sformatf("tie%0d_ifu_arready", i), ifu_arready, !exp_lsu);
      chk($sformatf("tie%0d_araddr", i), mem_araddr, exp_lsu ? 32'h200 : 32'h100);
      step();
      if (exp_lsu) lsu_arvalid = 0; else ifu_arvalid = 0;
      mem_rvalid = 1; mem_rdata = 32'hA0 + i;
      #1;
      chk($sformatf("tie%0d_lsu_rvalid", i), lsu_rvalid, exp_lsu);
      chk($sformatf("tie%0d_ifu_rvalid", i), ifu_rvalid, !exp_lsu);
      step();
      mem_rvalid = 0;
    end
    ifu_arvalid = 0; lsu_arvalid = 0;

    // ---------------- LSU read and write together: read first, bubble, write
    do_reset();
    lsu_arvalid = 1; lsu_araddr = 32'h0000_0300;
    lsu_awvalid = 1; lsu_awaddr = 32'h0000_0400;
    lsu_wvalid = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF;
    lsu_rready = 1; lsu_bready = 1;
    mem_arready = 1; mem_awready = 1; mem_wready = 1;
    step();
    chk("rw_rd_arvalid", mem_arvalid, 1);
    chk("rw_rd_no_aw", mem_awvalid, 0);
    chk("rw_rd_no_w", mem_wvalid, 0);
    step();
    lsu_arvalid = 0;
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rw_lsu_rdata", lsu_rdata, 32'h5555_AAAA);
    step();
    mem_rvalid = 0;
    #1;
    chk("rw_bubble_aw", mem_awvalid, 0);
    step();
    chk("rw_wr_awvalid", mem_awvalid, 1);
    chk("rw_wr_wdata", mem_wdata, 32'hCAFE_F00D);
    step();
    lsu_awvalid = 0; lsu_wvalid = 0;
    mem_bvalid = 1;
    #1;
    chk("rw_lsu_bvalid", lsu_bvalid, 1);
    step();
    mem_bvalid = 0;

    // ---------------- reset in the middle of a write
    do_reset();
    lsu_awvalid = 1; lsu_awaddr = 32'h0000_0500; lsu_bready = 1;
    mem_awready = 1; mem_wready = 1;
    step();
    chk("mid_aw_granted", mem_awvalid, 1);
    step();
    lsu_awvalid = 0;
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("mid_ifu_out", ifu_any, 0);
    chk("mid_lsu_out", lsu_any, 0);
    chk("mid_mem_out", mem_any, 0);
    mem_bvalid = 1;
    #1;
    chk("mid_no_bvalid", lsu_bvalid, 0);
    step();
    chk("mid_no_bvalid2", lsu_bvalid, 0);
    mem_bvalid = 0;

    // ---------------- SLVERR passthrough with zero-latency slave
    do_reset();
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0010; ifu_rready = 1;
    mem_arready = 1; mem_rvalid = 1; mem_rresp = 2'b10; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("err_idle_rvalid", ifu_rvalid, 0);
    step();
    chk("err_ifu_arready", ifu_arready, 1);
    chk("err_ifu_rvalid", ifu_rvalid, 1);
    chk("err_ifu_rresp", ifu_rresp, 2'b10);
    chk("err_ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
    step();
    ifu_arvalid = 0; mem_rvalid = 0; mem_rresp = 2'b00;
    #1;
    chk("err_back_idle", mem_rready, 0);
    step();
    chk("err_stays_idle", mem_any, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
